// File: rtl/mul_4_seq_pkg.sv
// Shared constants, state encoding and working-register layout for the 4x4 sequential multiplier.
package mul_4_seq_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned NITER = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned P_W   = 2 * W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Shift chain {C, A, Q}, most significant field first.
    typedef struct packed {
        logic         c;
        logic [W-1:0] a;
        logic [W-1:0] q;
    } acc_t;

endpackage

// File: rtl/adder_4.sv
// 4-bit ripple-carry adder with carry-in and carry-out.
module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cf
);

    logic [4:0] carry;

    always_comb begin
        carry    = 5'b0;
        s        = 4'b0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cf = carry[4];
    end

endmodule

// File: rtl/mul_4_seq.sv
// Unsigned 4x4 shift-and-add multiplier: one add/shift step per cycle, fixed 4-cycle run.
module mul_4_seq
    import mul_4_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] p
);

    state_t           state_q, state_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     q_q, q_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [W-1:0]     sum_s;
    logic             sum_cf;
    acc_t             step_pre;
    acc_t             step_post;

    adder_4 u_adder (
        .a   (a_q),
        .b   (m_q),
        .cin (1'b0),
        .s   (sum_s),
        .cf  (sum_cf)
    );

    // One add-then-shift step of the {C, A, Q} chain.
    always_comb begin
        step_pre   = '0;
        step_pre.q = q_q;
        if (q_q[0]) begin
            step_pre.c = sum_cf;
            step_pre.a = sum_s;
        end else begin
            step_pre.c = c_q;
            step_pre.a = a_q;
        end
        step_post = acc_t'({1'b0, step_pre[2*W:1]});
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    m_d     = a;
                    q_d     = b;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                c_d   = step_post.c;
                a_d   = step_post.a;
                q_d   = step_post.q;
                cnt_d = {cnt_q[1] ^ cnt_q[0], ~cnt_q[0]};
                if (cnt_q == CNT_W'(NITER - 1)) begin
                    state_d = ST_DONE;
                    p_d     = {step_post.a, step_post.q};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_mul_4_seq.sv
// Directed and randomized checks of mul_4_seq against a plain a*b reference.
module tb_mul_4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks      = 0;
    int errors      = 0;
    int done_seen   = 0;
    int overlap     = 0;
    int exp_done    = 0;
    logic [7:0] model_p = 8'h00;

    mul_4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (done === 1'b1 && busy === 1'b1) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; leaves the bench just after the negedge following edge k+5,
    // so the next call hits the earliest legal restart edge k+6.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv);
        logic [7:0] exp_p;
        exp_p = 8'(av) * 8'(bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_run1", 32'(busy), 32'd1);
        check("done_run1", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("busy_run", 32'(busy), 32'd1);
            check("p_hold_run", 32'(p), 32'(model_p));
        end
        start = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_p = exp_p;
        exp_done++;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("product", 32'(p), 32'(model_p));
        @(posedge clk);
        @(negedge clk);
        check("done_low", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("p_hold_idle", 32'(p), 32'(model_p));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic product, then back-to-back at the earliest restart
        run_op(4'd3, 4'd5);
        check("p_3x5", 32'(p), 32'h0F);
        run_op(4'd15, 4'd15);
        check("p_15x15", 32'(p), 32'hE1);
        run_op(4'd12, 4'd10);
        check("p_12x10", 32'(p), 32'h78);
        run_op(4'd0, 4'd9);
        check("p_0x9", 32'(p), 32'h00);

        // Idle with start low: p must hold
        repeat (3) @(negedge clk);
        check("idle_hold_p", 32'(p), 32'h00);
        check("idle_busy", 32'(busy), 32'd0);
        run_op(4'd1, 4'd8);
        check("p_1x8", 32'(p), 32'h08);

        // Start during RUN is ignored; inputs change mid-run
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 4'd11;
        b     = 4'd13;
        check("ignored_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_done++;
        model_p = 8'h31;
        check("ignored_done", 32'(done), 32'd1);
        check("p_7x7", 32'(p), 32'h31);
        @(posedge clk);
        @(negedge clk);
        check("ignored_done_low", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("no_second_done", 32'(done), 32'd0);
        check("no_second_busy", 32'(busy), 32'd0);
        check("p_still_49", 32'(p), 32'h31);

        // Asynchronous reset between edges mid-RUN
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_p = 8'h00;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_p", 32'(p), 32'h00);
        repeat (4) @(negedge clk);
        check("rst_held_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_p", 32'(p), 32'h00);
        run_op(4'd2, 4'd6);
        check("p_2x6", 32'(p), 32'h0C);

        // Randomized operands, back-to-back
        for (int n = 0; n < 24; n++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        check("done_pulse_count", 32'(done_seen), 32'(exp_done));
        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
